// File: rtl/jtkcpu_busarb_pkg.sv
// Shared types and constants for the jtkcpu bus arbiter.
package jtkcpu_busarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } busarb_state_t;

    localparam int         DMA_MAX_DEF = 4;
    localparam int         TOUT_DEF    = 255;
    localparam logic [7:0] FILL_DATA   = 8'hFF;

endpackage

// File: rtl/jtkcpu_busarb.sv
// Two-requester (CPU / DMA) arbiter for one shared memory port, one access in flight.
// Optional watchdog compiled in with JTKCPU_BUSARB_TIMEOUT_EN.
module jtkcpu_busarb
    import jtkcpu_busarb_pkg::*;
#(
    parameter int DMA_MAX = DMA_MAX_DEF,
    parameter int TOUT    = TOUT_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen2,
    input  logic        cpu_cs,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_dtack,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_dout,
    output logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic        mem_cs,
    output logic [23:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ok,
    output logic        tout_err
);

    localparam int               CNT_W   = $clog2(DMA_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX);

    busarb_state_t    st, st_nx;
    logic             served;
    logic [CNT_W-1:0] dma_cnt;
    logic             cpu_want;
    logic             grant_cpu, grant_dma;
    logic             cpu_done, dma_done;
    logic             acc_done, tout_hit;
    logic [7:0]       rd_data;

    assign cpu_want  = cpu_cs & ~served;
    assign cpu_dtack = ~cpu_want;
    assign acc_done  = mem_cs & (mem_ok | tout_hit);
    // A watchdog completion returns the fill pattern instead of bus data.
    assign rd_data   = mem_ok ? mem_din : FILL_DATA;

    always_comb begin
        st_nx     = st;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        cpu_done  = 1'b0;
        dma_done  = 1'b0;
        case (st)
            IDLE: begin
                if (cpu_want && (!dma_req || dma_cnt == CNT_MAX)) begin
                    grant_cpu = 1'b1;
                    st_nx     = CPU;
                end else if (dma_req) begin
                    grant_dma = 1'b1;
                    st_nx     = DMA;
                end
            end
            CPU: begin
                if (acc_done) begin
                    cpu_done = 1'b1;
                    st_nx    = IDLE;
                end
            end
            DMA: begin
                if (acc_done) begin
                    dma_done = 1'b1;
                    st_nx    = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 24'd0;
            mem_dout <= 8'd0;
            cpu_din  <= 8'd0;
            dma_din  <= 8'd0;
            dma_ack  <= 1'b0;
            served   <= 1'b0;
            dma_cnt  <= '0;
        end else begin
            st      <= st_nx;
            dma_ack <= 1'b0;
            if (grant_cpu) begin
                mem_cs   <= 1'b1;
                mem_addr <= cpu_addr;
                mem_we   <= cpu_we;
                mem_dout <= cpu_dout;
            end
            if (grant_dma) begin
                mem_cs   <= 1'b1;
                mem_addr <= dma_addr;
                mem_we   <= dma_we;
                mem_dout <= dma_dout;
            end
            if (cpu_done) begin
                mem_cs <= 1'b0;
                if (!mem_we) cpu_din <= rd_data;
            end
            if (dma_done) begin
                mem_cs  <= 1'b0;
                dma_din <= rd_data;
                dma_ack <= 1'b1;
            end
            // served drops on the CPU clock enable that lets the CPU finish its cycle
            if (cen2 && cpu_dtack && served) served <= 1'b0;
            else if (cpu_done)               served <= 1'b1;
            if (!cpu_cs || grant_cpu)
                dma_cnt <= '0;
            else if (grant_dma && cpu_want && dma_cnt != CNT_MAX)
                dma_cnt <= dma_cnt + CNT_W'(1);
        end
    end

`ifdef JTKCPU_BUSARB_TIMEOUT_EN
    if (TOUT > 0) begin : g_wdog
        localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);
        logic [7:0] tcnt;

        assign tout_hit = mem_cs & (tcnt == TOUT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tcnt     <= 8'd0;
                tout_err <= 1'b0;
            end else begin
                if (mem_cs && !acc_done) tcnt <= tcnt + 8'd1;
                else                     tcnt <= 8'd0;
                if (tout_hit && !mem_ok) tout_err <= 1'b1;
            end
        end
    end else begin : g_no_wdog
        assign tout_hit = 1'b0;
        assign tout_err = 1'b0;
    end
`else
    logic unused_tout;
    assign unused_tout = ^8'(TOUT);
    assign tout_hit    = 1'b0;
    assign tout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jtkcpu_busarb.sv
// Directed and randomized bench for jtkcpu_busarb against a transaction-level model.
module tb_jtkcpu_busarb;

    localparam int DMA_MAX_P = 4;
    localparam int TOUT_P    = 8;

    logic        clk = 1'b0, rst_n = 1'b0, cen2 = 1'b0;
    logic        cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [23:0] cpu_addr = 24'd0;
    logic [7:0]  cpu_dout = 8'd0;
    logic [7:0]  cpu_din;
    logic        cpu_dtack;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [23:0] dma_addr = 24'd0;
    logic [7:0]  dma_dout = 8'd0;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic        mem_cs, mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'd0;
    logic        mem_ok = 1'b0;
    logic        tout_err;

    always #5 clk = ~clk;

    jtkcpu_busarb #(.DMA_MAX(DMA_MAX_P), .TOUT(TOUT_P)) dut (
        .clk(clk), .rst_n(rst_n), .cen2(cen2),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_dtack(cpu_dtack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_dout(dma_dout),
        .dma_din(dma_din), .dma_ack(dma_ack),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ok(mem_ok), .tout_err(tout_err)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: the access in flight (or the last one granted) plus per-requester results
    typedef struct {
        bit          is_dma;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  dout;
        int          cycles;
    } acc_t;

    acc_t       acc;
    bit         busy, m_served, e_ack, e_tout;
    int         streak, rsp_wait;
    logic [7:0] e_cpu_din, e_dma_din;

    function automatic logic [7:0] mem_pat(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; m_served = 0; e_ack = 0; e_tout = 0;
        streak = 0; rsp_wait = 0;
        e_cpu_din = 8'd0; e_dma_din = 8'd0;
        acc.is_dma = 0; acc.addr = 24'd0; acc.we = 1'b0; acc.dout = 8'd0; acc.cycles = 0;
    endtask

    // Applies the arbitration rules to the inputs presented for the coming clock edge.
    task automatic model_edge();
        bit         cpu_want, clr, done;
        logic [7:0] d;
        cpu_want = cpu_cs && !m_served;
        clr      = cen2 && m_served;
        e_ack    = 0;
        if (busy) begin
            acc.cycles++;
            done = mem_ok;
            d    = mem_din;
`ifdef JTKCPU_BUSARB_TIMEOUT_EN
            if (!mem_ok && acc.cycles == TOUT_P) begin
                done = 1; d = 8'hFF; e_tout = 1;
            end
`endif
            if (done) begin
                busy = 0;
                if (acc.is_dma) begin
                    e_ack = 1; e_dma_din = d;
                end else begin
                    m_served = 1;
                    if (!acc.we) e_cpu_din = d;
                end
            end
        end else if (cpu_want && (!dma_req || streak == DMA_MAX_P)) begin
            busy = 1; acc.is_dma = 0; acc.addr = cpu_addr; acc.we = cpu_we;
            acc.dout = cpu_dout; acc.cycles = 0; streak = 0;
            rsp_wait = $urandom_range(0, 3);
        end else if (dma_req) begin
            busy = 1; acc.is_dma = 1; acc.addr = dma_addr; acc.we = dma_we;
            acc.dout = dma_dout; acc.cycles = 0;
            if (cpu_want && streak < DMA_MAX_P) streak++;
            rsp_wait = $urandom_range(0, 3);
        end
        if (!cpu_cs) streak = 0;
        if (clr) m_served = 0;
    endtask

    task automatic check_outputs();
        chk("mem_cs",    mem_cs,    busy);
        chk("mem_addr",  mem_addr,  acc.addr);
        chk("mem_we",    mem_we,    acc.we);
        chk("mem_dout",  mem_dout,  acc.dout);
        chk("cpu_dtack", cpu_dtack, !(cpu_cs && !m_served));
        chk("dma_ack",   dma_ack,   e_ack);
        chk("dma_din",   dma_din,   e_dma_din);
        chk("cpu_din",   cpu_din,   e_cpu_din);
        chk("tout_err",  tout_err,  e_tout);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic new_cpu();
        cpu_cs = 1; cpu_addr = 24'($urandom); cpu_we = 1'($urandom); cpu_dout = 8'($urandom);
    endtask

    task automatic new_dma();
        dma_req = 1; dma_addr = 24'($urandom); dma_we = 1'($urandom); dma_dout = 8'($urandom);
    endtask

    initial begin
        int acks;
        bit served_seen;

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // CPU read with a slow memory
        cpu_addr = 24'h012345; cpu_we = 0; cpu_cs = 1; cen2 = 0;
        step();
        chk("t1_dtack_low", cpu_dtack, 1'b0);
        repeat (2) step();
        mem_ok = 1; mem_din = 8'hA5;
        step();
        mem_ok = 0; mem_din = 8'h00;
        chk("t1_cpu_din", cpu_din, 8'hA5);
        chk("t1_dtack_high", cpu_dtack, 1'b1);
        repeat (3) step();
        chk("t1_single_burst", mem_cs, 1'b0);
        cpu_cs = 0; cen2 = 1;
        step();
        cen2 = 0;

        // CPU write
        cpu_addr = 24'h000010; cpu_we = 1; cpu_dout = 8'h5A; cpu_cs = 1;
        step();
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_dout", mem_dout, 8'h5A);
        mem_ok = 1; mem_din = 8'h33;
        step();
        chk("t2_cpu_din_kept", cpu_din, 8'hA5);
        chk("t2_served", cpu_dtack, 1'b1);
        mem_ok = 0; cpu_cs = 0; cpu_we = 0; cen2 = 1;
        step();
        cen2 = 0;

        // Simultaneous requests: DMA first, CPU next
        cpu_addr = 24'h111111; cpu_cs = 1;
        dma_addr = 24'h222222; dma_we = 0; dma_req = 1;
        step();
        chk("t3_dma_first", mem_addr, 24'h222222);
        mem_ok = 1; mem_din = 8'h3C;
        step();
        chk("t3_dma_ack", dma_ack, 1'b1);
        chk("t3_dma_din", dma_din, 8'h3C);
        dma_req = 0; mem_ok = 0;
        step();
        chk("t3_cpu_next", mem_addr, 24'h111111);
        mem_ok = 1; mem_din = 8'h4B;
        step();
        chk("t3_cpu_din", cpu_din, 8'h4B);
        mem_ok = 0; cpu_cs = 0; cen2 = 1;
        step();
        cen2 = 0;

        // DMA burst against a waiting CPU
        cpu_addr = 24'h0ABCDE; cpu_cs = 1;
        dma_addr = 24'h300000; dma_req = 1;
        acks = 0; served_seen = 0;
        for (int i = 0; i < 60 && !served_seen; i++) begin
            mem_ok = busy; mem_din = 8'($urandom);
            step();
            if (dma_ack) acks++;
            if (cpu_cs && cpu_dtack) served_seen = 1;
        end
        chk("t4_dma_acks", acks, DMA_MAX_P);
        chk("t4_cpu_served", served_seen, 1'b1);
        dma_req = 0; mem_ok = 0; cpu_cs = 0; cen2 = 1;
        step();
        cen2 = 0;

        // Reset in the middle of a DMA access
        dma_addr = 24'h456789; dma_req = 1;
        step();
        step();
        chk("t5_in_flight", mem_cs, 1'b1);
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        dma_req = 0;
        #2 rst_n = 1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dma_ack) acks++;
        end
        chk("t5_no_ack", acks, 0);

        // Memory never answers
        cpu_addr = 24'h000055; cpu_we = 0; cpu_cs = 1; cen2 = 0;
        step();
        repeat (12) step();
`ifdef JTKCPU_BUSARB_TIMEOUT_EN
        chk("t6_fill_data", cpu_din, 8'hFF);
        chk("t6_tout_err", tout_err, 1'b1);
        chk("t6_released", mem_cs, 1'b0);
        cpu_cs = 0; cen2 = 1;
        step();
        cen2 = 0;
        repeat (3) step();
        chk("t6_sticky", tout_err, 1'b1);
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        #2 rst_n = 1;
`else
        chk("t6_mem_cs_held", mem_cs, 1'b1);
        chk("t6_no_err", tout_err, 1'b0);
        mem_ok = 1; mem_din = 8'h77;
        step();
        mem_ok = 0; cpu_cs = 0; cen2 = 1;
        step();
        cen2 = 0;
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cen2 = 1'($urandom);
            if (!cpu_cs) begin
                if ($urandom_range(0, 2) == 0) new_cpu();
            end else if (m_served && cen2) begin
                if ($urandom_range(0, 1) == 1) new_cpu();
                else cpu_cs = 0;
            end else if (busy && !acc.is_dma) begin
                cpu_addr = 24'($urandom); cpu_we = 1'($urandom); cpu_dout = 8'($urandom);
            end
            if (e_ack) begin
                if ($urandom_range(0, 1) == 1) new_dma();
                else dma_req = 0;
            end else if (!dma_req) begin
                if ($urandom_range(0, 2) == 0) new_dma();
            end else if (busy && acc.is_dma) begin
                dma_addr = 24'($urandom); dma_we = 1'($urandom); dma_dout = 8'($urandom);
            end
            if (busy) begin
                if (rsp_wait == 0) begin
                    mem_ok = 1; mem_din = mem_pat(acc.addr);
                end else begin
                    mem_ok = 0; mem_din = 8'($urandom); rsp_wait--;
                end
            end else begin
                mem_ok = 1'($urandom); mem_din = 8'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
